dp_ir_reg: RTL
==============

# dp_ir_reg

Parametrised JTAG instruction register for the debug TAP: capture/shift/update IR chain, held instruction latch and registered data-register select decode. It sits between the TAP controller FSM and the DR mux, replacing the fixed 5-bit combinational decoder. IR length and all instruction codes are parameters. It adds a sticky invalid-instruction flag and an update strobe.

## Interface
- IR_LEN, 5: instruction register length in bits; legal values are 2 to 16.
- IDCODE_C, 5'h01: IDCODE opcode, IR_LEN wide; also the reset/TLR value.
- DTMCS_C, 5'h10: DTMCS opcode.
- DMI_C, 5'h11: DMI opcode.
- RSV_LO, 5'h12: lowest reserved opcode; reserved opcodes select BYPASS.
- RSV_HI, 5'h17: highest reserved opcode, inclusive.
- tck  in  1  TAP clock; all state changes on the rising edge.
- trst  in  1  reset; synchronous, active-high.
- tlr  in  1  TAP is in Test-Logic-Reset.
- capture_ir  in  1  TAP is in Capture-IR.
- shift_ir  in  1  TAP is in Shift-IR.
- update_ir  in  1  TAP is in Update-IR.
- tdi  in  1  serial input.
- ir_tdo  out  1  serial output, equal to the shift register LSB.
- ir_value  out  IR_LEN  latched instruction.
- bsr_sel  out  4  registered DR select, using the SEL_* encodings.
- ir_upd  out  1  one-cycle pulse after each update.
- ir_invalid  out  1  sticky flag: an undefined opcode has been latched.

## Operation
- Shift register sr[IR_LEN-1:0]:
  - capture_ir: sr <= {0…0, 2'b01}, as IEEE 1149.1 requires.
  - shift_ir: sr <= {tdi, sr[IR_LEN-1:1]}, so bits shift out LSB first.
  - Otherwise sr holds.
- Latch ir_value: update_ir loads sr. tlr or trst loads IDCODE_C. Otherwise it holds.
- Decode, evaluated on the value being latched and registered into bsr_sel:
  - IDCODE_C → SEL_IDCODE.
  - DTMCS_C → SEL_DTMCS.
  - DMI_C → SEL_DMI.
  - All-zeros, all-ones, or RSV_LO ≤ code ≤ RSV_HI → SEL_BYPASS.
  - Any other code → SEL_IDCODE.
- ir_invalid is set on an update whose code falls into the "other" branch. It is cleared only by trst or tlr. A later valid update does not clear it.
- ir_upd is 1 in the cycle after update_ir is sampled. Otherwise it is 0.
- Priority within one cycle: trst > tlr > update_ir > capture_ir > shift_ir. The TAP asserts these mutually exclusively; the priority applies regardless.
- Reset values:
  - sr = {0…0, 01} and ir_tdo = 1.
  - ir_value = IDCODE_C and bsr_sel = SEL_IDCODE.
  - ir_upd = 0 and ir_invalid = 0.
- A reset mid-shift discards the partial shift; ir_value returns to IDCODE_C.

## Timing
- ir_tdo is sr[0], a registered output. It is valid from the edge after capture/shift. Any falling-edge retiming of TDO is done in the TAP top, not here.
- Update-to-output latency is 1 cycle: ir_value, bsr_sel, ir_invalid and ir_upd all change on the same edge that samples update_ir.
- bsr_sel and ir_value never change during Capture-IR or Shift-IR. The DR path stays stable across IR scans.
- Shifting more than IR_LEN bits is legal: the last IR_LEN bits shifted in are the ones latched.
- An update with no preceding shift latches the captured pattern 0…01. For IR_LEN=5 this is IDCODE.

## Structure
- SEL_IDCODE, SEL_DTMCS, SEL_DMI and SEL_BYPASS stay in the shared dp_constants package.
- Add default opcode localparams to the same package:
  - IR_LEN_DEF, IDCODE_C, DTMCS_C and DMI_C.
  - The RSV range bounds.
  - IR_CAPTURE = 2'b01.
- One sub-module: dp_ir_sel_dec. It is a parametrised pure-combinational decode of a code into sel plus an invalid flag. The parent registers its output on update and on reset.

## Test plan
- Reset: hold trst for 2 cycles → ir_value=5'h01, bsr_sel=SEL_IDCODE, ir_tdo=1, ir_invalid=0, ir_upd=0.
- Full IR scan:
  - Stimulus: capture, then shift tdi=1,0,0,0,1 (LSB first), then update.
  - ir_tdo sequence: 1,0,0,0,0.
  - After update: ir_value=5'h11, bsr_sel=SEL_DMI, and ir_upd high for exactly 1 cycle.
- Bypass codes: load 5'h00, 5'h1F, 5'h12 and 5'h17 in turn → SEL_BYPASS for each, ir_invalid stays 0.
- Invalid code and sticky flag:
  - Load 5'h05 → bsr_sel=SEL_IDCODE, ir_invalid=1.
  - Then load 5'h10 → SEL_DTMCS with ir_invalid still 1.
  - Then assert tlr → ir_invalid=0 and ir_value=5'h01.
- Overshift and reset mid-scan:
  - Shift 8 bits, then update → the last 5 bits are latched.
  - In a second scan, assert trst after 3 shifts → sr=00001 and ir_value=5'h01, and no ir_upd pulse.
- Parameter variant IR_LEN=8 with DMI_C=8'h11:
  - Scan 8'h11 → SEL_DMI.
  - Scan 8'hFF → SEL_BYPASS.
  - Capture-then-shift yields tdo 1,0,0,0,0,0,0,0.

Source files
------------

// File: rtl/dp_constants.sv
// Shared debug-port constants: DR select encodings and default IR opcodes.
package dp_constants;

  typedef logic [3:0] sel_t;

  localparam sel_t SEL_BYPASS = 4'b0001;
  localparam sel_t SEL_IDCODE = 4'b0010;
  localparam sel_t SEL_DTMCS  = 4'b0100;
  localparam sel_t SEL_DMI    = 4'b1000;

  localparam int         IR_LEN_DEF = 5;
  localparam logic [4:0] IDCODE_C   = 5'h01;
  localparam logic [4:0] DTMCS_C    = 5'h10;
  localparam logic [4:0] DMI_C      = 5'h11;
  localparam logic [4:0] RSV_LO     = 5'h12;
  localparam logic [4:0] RSV_HI     = 5'h17;
  localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/dp_ir_sel_dec.sv
// Combinational decode of an IR code into a DR select and invalid flag.
module dp_ir_sel_dec
  import dp_constants::*;
#(
  parameter int                IR_LEN   = IR_LEN_DEF,
  parameter logic [IR_LEN-1:0] IDCODE_C = IR_LEN'(dp_constants::IDCODE_C),
  parameter logic [IR_LEN-1:0] DTMCS_C  = IR_LEN'(dp_constants::DTMCS_C),
  parameter logic [IR_LEN-1:0] DMI_C    = IR_LEN'(dp_constants::DMI_C),
  parameter logic [IR_LEN-1:0] RSV_LO   = IR_LEN'(dp_constants::RSV_LO),
  parameter logic [IR_LEN-1:0] RSV_HI   = IR_LEN'(dp_constants::RSV_HI)
) (
  input  logic [IR_LEN-1:0] code,
  output logic [3:0]        sel,
  output logic              invalid
);

  logic hit_id;
  logic hit_dt;
  logic hit_dmi;
  logic hit_byp;
  logic byp_raw;

  // Hits are masked into a one-hot set so earlier codes win on overlap.
  assign byp_raw = (code == '0) || (&code) ||
                   ((code >= RSV_LO) && (code <= RSV_HI));
  assign hit_id  = (code == IDCODE_C);
  assign hit_dt  = (code == DTMCS_C) && !hit_id;
  assign hit_dmi = (code == DMI_C) && !hit_id && !hit_dt;
  assign hit_byp = byp_raw && !(hit_id || hit_dt || hit_dmi);

  always_comb begin
    sel     = SEL_IDCODE;
    invalid = 1'b0;
    unique case (1'b1)
      hit_id:  sel = SEL_IDCODE;
      hit_dt:  sel = SEL_DTMCS;
      hit_dmi: sel = SEL_DMI;
      hit_byp: sel = SEL_BYPASS;
      default: begin
        sel     = SEL_IDCODE;
        invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dp_ir_reg.sv
// JTAG instruction register: capture/shift/update chain, latch and
// registered DR select decode with sticky invalid flag.
module dp_ir_reg
  import dp_constants::*;
#(
  parameter int                IR_LEN   = IR_LEN_DEF,
  parameter logic [IR_LEN-1:0] IDCODE_C = IR_LEN'(dp_constants::IDCODE_C),
  parameter logic [IR_LEN-1:0] DTMCS_C  = IR_LEN'(dp_constants::DTMCS_C),
  parameter logic [IR_LEN-1:0] DMI_C    = IR_LEN'(dp_constants::DMI_C),
  parameter logic [IR_LEN-1:0] RSV_LO   = IR_LEN'(dp_constants::RSV_LO),
  parameter logic [IR_LEN-1:0] RSV_HI   = IR_LEN'(dp_constants::RSV_HI)
) (
  input  logic              tck,
  input  logic              trst,
  input  logic              tlr,
  input  logic              capture_ir,
  input  logic              shift_ir,
  input  logic              update_ir,
  input  logic              tdi,
  output logic              ir_tdo,
  output logic [IR_LEN-1:0] ir_value,
  output logic [3:0]        bsr_sel,
  output logic              ir_upd,
  output logic              ir_invalid
);

  localparam logic [IR_LEN-1:0] CAP = IR_LEN'(IR_CAPTURE);

  logic [IR_LEN-1:0] sr;
  logic [3:0]        dec_sel;
  logic              dec_bad;

  dp_ir_sel_dec #(
    .IR_LEN   (IR_LEN),
    .IDCODE_C (IDCODE_C),
    .DTMCS_C  (DTMCS_C),
    .DMI_C    (DMI_C),
    .RSV_LO   (RSV_LO),
    .RSV_HI   (RSV_HI)
  ) u_dec (
    .code    (sr),
    .sel     (dec_sel),
    .invalid (dec_bad)
  );

  assign ir_tdo = sr[0];

  // TLR behaves like trst: any partial scan is discarded.
  always_ff @(posedge tck) begin
    if (trst || tlr) begin
      sr         <= CAP;
      ir_value   <= IDCODE_C;
      bsr_sel    <= SEL_IDCODE;
      ir_upd     <= 1'b0;
      ir_invalid <= 1'b0;
    end else begin
      ir_upd <= update_ir;
      if (update_ir) begin
        ir_value <= sr;
        bsr_sel  <= dec_sel;
        if (dec_bad) ir_invalid <= 1'b1;
      end else if (capture_ir) begin
        sr <= CAP;
      end else if (shift_ir) begin
        sr <= {tdi, sr[IR_LEN-1:1]};
      end
    end
  end

endmodule
